// File: rtl/wb_dma_copier.sv
// -----------------------------------------------------------------------------
// wb_dma_copier
//   Wishbone classic bus master that copies a block of 32-bit words from a
//   source address range to a destination address range. Each word is moved
//   as one single read followed by one single write, with a one-cycle idle gap
//   after every bus access.
//
// Parameters
//   LEN_W    width of the word-count input and internal counter
//   TIMEOUT  max cycles a strobe may wait for ack_i before the copy aborts
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      synchronous reset, active-low
//   start_i    one-cycle request, honoured only while idle
//   src_adr_i  source byte address (bits [1:0] ignored)
//   dst_adr_i  destination byte address (bits [1:0] ignored)
//   len_i      number of words to copy
//   busy_o     copy in progress
//   done_o     one-cycle pulse on successful completion
//   err_o      sticky timeout flag, cleared by the next accepted start
//   cyc_o/stb_o/we_o/sel_o/adr_o/dat_o   Wishbone master outputs
//   dat_i/ack_i                          Wishbone master inputs
// -----------------------------------------------------------------------------
module wb_dma_copier #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_adr_i,
  input  logic [31:0]      dst_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [3:0]       sel_o,
  output logic [31:0]      adr_o,
  output logic [31:0]      dat_o,
  input  logic [31:0]      dat_i,
  input  logic             ack_i
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  // A timeout does not get its own state: the abort cycle lands directly in
  // IDLE with err set, so err_o and busy_o=0 appear together.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RGAP,
    S_WR,
    S_WGAP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [31:0]        buf_q, buf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        adr_q, adr_d;
  logic               ack_hit;

  // ack_i only means something while our strobe is up.
  assign ack_hit = ack_i & cyc_q;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          if (len_i != '0) begin
            src_d   = src_adr_i & ~32'h3;
            dst_d   = dst_adr_i & ~32'h3;
            cnt_d   = len_i;
            state_d = S_RD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD: begin
        if (ack_hit) begin
          buf_d   = dat_i;
          state_d = S_RGAP;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      // Strobe drops for one cycle so a slave whose ack lags its strobe by a
      // cycle cannot have that late ack taken as the write acknowledge.
      S_RGAP: state_d = S_WR;
      S_WR: begin
        if (ack_hit) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_d == '0) ? S_DONE : S_WGAP;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WGAP:  state_d = S_RD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Counts wait cycles of the current strobe; any state change restarts it.
    tmo_d = ((state_q == S_RD || state_q == S_WR) && state_d == state_q)
            ? tmo_q + TMO_W'(1) : '0;

    // Bus and status outputs are registered from the next state so they line
    // up exactly with the state they describe.
    cyc_d  = (state_d == S_RD) || (state_d == S_WR);
    we_d   = (state_d == S_WR);
    sel_d  = cyc_d ? 4'hF : 4'h0;
    busy_d = cyc_d || (state_d == S_RGAP) || (state_d == S_WGAP);
    done_d = (state_d == S_DONE);
    adr_d  = adr_q;
    if (state_d == S_RD) begin
      adr_d = src_d;
    end else if (state_d == S_WR) begin
      adr_d = dst_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign cyc_o  = cyc_q;
  assign stb_o  = cyc_q;
  assign we_o   = we_q;
  assign sel_o  = sel_q;
  assign adr_o  = adr_q;
  assign dat_o  = buf_q;

endmodule

// File: tb/tb_wb_dma_copier.sv
// -----------------------------------------------------------------------------
// tb_wb_dma_copier
//   Directed bench for wb_dma_copier with a small Wishbone RAM slave whose ack
//   is registered from the strobe (so it lingers one cycle after each access)
//   and can be delayed by a number of wait states or disabled entirely.
// -----------------------------------------------------------------------------
module tb_wb_dma_copier;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] src_adr_i;
  logic [31:0] dst_adr_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic        ack_i = 1'b0;

  always #5 clk = ~clk;

  wb_dma_copier #(.LEN_W(16), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .src_adr_i(src_adr_i), .dst_adr_i(dst_adr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
  );

  // RAM slave
  logic        slave_en;
  int          ws;
  logic        load_en;
  logic [9:0]  load_idx;
  logic [31:0] load_dat;
  logic [31:0] mem [0:1023];
  int          wcnt = 0;

  assign dat_i = mem[adr_o[11:2]];

  always @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_dat;
    else if (stb_o && we_o && ack_i) mem[adr_o[11:2]] <= dat_o;
    if (slave_en && stb_o) begin
      ack_i <= (wcnt >= ws);
      wcnt  <= wcnt + 1;
    end else begin
      ack_i <= 1'b0;
      wcnt  <= 0;
    end
  end

  // Bus monitors
  int wr_acks = 0, rd_acks = 0, done_cnt = 0, stb_cyc = 0, sel_bad = 0, order_bad = 0;
  always @(posedge clk) begin
    if (stb_o && we_o && ack_i)  wr_acks  <= wr_acks + 1;
    if (stb_o && !we_o && ack_i) rd_acks  <= rd_acks + 1;
    if (done_o)                  done_cnt <= done_cnt + 1;
    if (stb_o)                   stb_cyc  <= stb_cyc + 1;
    if (stb_o && sel_o != 4'hF)  sel_bad  <= sel_bad + 1;
    if (stb_o && we_o && rd_acks <= wr_acks) order_bad <= order_bad + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] idx, input logic [31:0] d);
    load_en  = 1'b1;
    load_idx = idx;
    load_dat = d;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after the
  // accepting clock edge (cycle 1).
  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    start_i   = 1'b1;
    src_adr_i = s;
    dst_adr_i = d;
    len_i     = l;
    @(negedge clk);
    start_i   = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!done_o && c < 400) begin
      @(negedge clk);
      c++;
    end
  endtask

  localparam logic [31:0] A0 = 32'hA0A0_1111, A1 = 32'hA1A1_2222,
                          A2 = 32'hA2A2_3333, A3 = 32'hA3A3_4444;
  localparam logic [31:0] B0 = 32'hB0B0_5555, B1 = 32'hB1B1_6666;
  localparam logic [31:0] C0 = 32'hC0C0_7777, C1 = 32'hC1C1_8888, C2 = 32'hC2C2_9999;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  initial begin
    int c, n, d0, w0, s0;
    rst_i = 1'b0; start_i = 1'b0; src_adr_i = '0; dst_adr_i = '0; len_i = '0;
    slave_en = 1'b1; ws = 0; load_en = 1'b0; load_idx = '0; load_dat = '0;

    repeat (3) @(negedge clk);
    chk("rst_cyc",  {31'd0, cyc_o},  32'd0);
    chk("rst_stb",  {31'd0, stb_o},  32'd0);
    chk("rst_we",   {31'd0, we_o},   32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err",  {31'd0, err_o},  32'd0);
    chk("rst_sel",  {28'd0, sel_o},  32'd0);
    chk("rst_adr",  adr_o, 32'd0);
    chk("rst_dat",  dat_o, 32'd0);

    poke(10'h040, A0); poke(10'h041, A1); poke(10'h042, A2); poke(10'h043, A3);
    poke(10'h044, B0); poke(10'h045, B1); poke(10'h102, SENT);
    poke(10'h048, C0); poke(10'h049, C1); poke(10'h04A, C2); poke(10'h143, SENT);
    poke(10'h180, SENT); poke(10'h181, SENT); poke(10'h0C0, SENT);
    rst_i = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy_o}, 32'd0);

    // 1: four-word copy with a zero-wait slave
    d0 = done_cnt; w0 = wr_acks;
    start_copy(32'h100, 32'h200, 16'd4);
    chk("t1_stb_c1",  {31'd0, stb_o},  32'd1);
    chk("t1_busy_c1", {31'd0, busy_o}, 32'd1);
    chk("t1_adr_c1",  adr_o, 32'h100);
    chk("t1_we_c1",   {31'd0, we_o},   32'd0);
    repeat (2) @(negedge clk);
    chk("t1_rgap_stb", {31'd0, stb_o}, 32'd0);
    @(negedge clk);
    chk("t1_wr_we",  {31'd0, we_o}, 32'd1);
    chk("t1_wr_adr", adr_o, 32'h200);
    chk("t1_wr_dat", dat_o, A0);
    wait_done(4, c);
    chk("t1_done_cycle", c, 32'd24);
    chk("t1_busy_done", {31'd0, busy_o}, 32'd0);
    chk("t1_err", {31'd0, err_o}, 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", {31'd0, done_o}, 32'd0);
    chk("t1_m0", mem[10'h080], A0);
    chk("t1_m1", mem[10'h081], A1);
    chk("t1_m2", mem[10'h082], A2);
    chk("t1_m3", mem[10'h083], A3);
    chk("t1_done_cnt", done_cnt - d0, 32'd1);
    chk("t1_writes",   wr_acks - w0,  32'd4);

    // 2: zero-length request
    d0 = done_cnt; s0 = stb_cyc;
    start_copy(32'h100, 32'h700, 16'd0);
    chk("t2_done", {31'd0, done_o}, 32'd1);
    chk("t2_stb",  {31'd0, stb_o},  32'd0);
    chk("t2_busy", {31'd0, busy_o}, 32'd0);
    chk("t2_err",  {31'd0, err_o},  32'd0);
    @(negedge clk);
    chk("t2_done_low", {31'd0, done_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t2_no_stb",   stb_cyc - s0,  32'd0);
    chk("t2_done_cnt", done_cnt - d0, 32'd1);

    // 3: slave never acks -> timeout, then a fresh start clears err
    slave_en = 1'b0;
    d0 = done_cnt;
    start_copy(32'h100, 32'h300, 16'd1);
    n = 0;
    while (stb_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("t3_stb_cycles", n, 32'd8);
    chk("t3_err",  {31'd0, err_o},  32'd1);
    chk("t3_busy", {31'd0, busy_o}, 32'd0);
    chk("t3_cyc",  {31'd0, cyc_o},  32'd0);
    chk("t3_no_done", done_cnt - d0, 32'd0);
    repeat (2) @(negedge clk);
    chk("t3_err_sticky", {31'd0, err_o}, 32'd1);
    slave_en = 1'b1;
    start_copy(32'h100, 32'h300, 16'd1);
    chk("t3_err_clr", {31'd0, err_o}, 32'd0);
    wait_done(1, c);
    chk("t3_done_cycle", c, 32'd6);
    @(negedge clk);
    chk("t3_m0", mem[10'h0C0], A0);

    // 4: three wait states, two words, late acks linger into the gaps
    ws = 3;
    w0 = wr_acks;
    start_copy(32'h110, 32'h400, 16'd2);
    wait_done(1, c);
    chk("t4_done_cycle", c, 32'd24);
    @(negedge clk);
    chk("t4_m0", mem[10'h100], B0);
    chk("t4_m1", mem[10'h101], B1);
    chk("t4_m2_untouched", mem[10'h102], SENT);
    chk("t4_writes",  wr_acks - w0, 32'd2);
    chk("t4_sel_bad", sel_bad,   32'd0);
    chk("t4_order",   order_bad, 32'd0);
    ws = 0;

    // 5: second start mid-copy is ignored
    d0 = done_cnt; w0 = wr_acks;
    start_copy(32'h120, 32'h500, 16'd3);
    repeat (4) @(negedge clk);
    start_i = 1'b1; src_adr_i = 32'h0; dst_adr_i = 32'h800; len_i = 16'd5;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(6, c);
    chk("t5_done_cycle", c, 32'd18);
    @(negedge clk);
    chk("t5_writes",   wr_acks - w0,  32'd3);
    chk("t5_m0", mem[10'h140], C0);
    chk("t5_m1", mem[10'h141], C1);
    chk("t5_m2", mem[10'h142], C2);
    chk("t5_m3_untouched", mem[10'h143], SENT);
    s0 = stb_cyc;
    repeat (8) @(negedge clk);
    chk("t5_idle_after", stb_cyc - s0, 32'd0);
    chk("t5_done_cnt", done_cnt - d0, 32'd1);

    // 6: reset during a write strobe, then a clean restart
    d0 = done_cnt;
    start_copy(32'h100, 32'h600, 16'd2);
    repeat (3) @(negedge clk);
    chk("t6_in_wr", {30'd0, stb_o, we_o}, 32'd3);
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    chk("t6_cyc",  {31'd0, cyc_o},  32'd0);
    chk("t6_stb",  {31'd0, stb_o},  32'd0);
    chk("t6_busy", {31'd0, busy_o}, 32'd0);
    chk("t6_done", {31'd0, done_o}, 32'd0);
    repeat (30) @(negedge clk);
    chk("t6_no_done", done_cnt - d0, 32'd0);
    chk("t6_no_write", mem[10'h180], SENT);
    start_copy(32'h100, 32'h600, 16'd2);
    wait_done(1, c);
    chk("t6_done_cycle", c, 32'd12);
    @(negedge clk);
    chk("t6_m0", mem[10'h180], A0);
    chk("t6_m1", mem[10'h181], A1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
